// File: rtl/dds_phase_acc.sv
// dds_phase_acc
//
// DDS phase accumulator with a qualifier on its phase increment. The bus
// register decoder rewrites the 48-bit increment one 16-bit word at a time.
// This block takes a new increment only after it has been stable for SETTLE
// consecutive cycles. As a result, a half-written value never reaches the
// adder. The committed increment is added to PHASE every enabled cycle.
//
// Parameters
//   ADDR_W  waveform-table address width, 1..32 (WAVE_ADDR = PHASE[47:48-ADDR_W])
//   SETTLE  stable cycles required before commit, 1..255
//
// Ports
//   CLK133       in   1       system clock, rising edge
//   RST_N        in   1       synchronous active-low reset
//   DDS_PINC     in   48      raw increment from the register decoder
//   ENABLE       in   1       1 = accumulate each cycle, 0 = hold phase
//   PHASE_CLR    in   1       synchronous phase clear, overrides ENABLE
//   PINC_ACTIVE  out  48      committed increment used by the accumulator
//   PHASE        out  48      accumulator register
//   WAVE_ADDR    out  ADDR_W  top ADDR_W bits of PHASE
//   WRAP         out  1       one-cycle pulse on carry out of the 48-bit add
//   PINC_BUSY    out  1       candidate increment is settling
module dds_phase_acc #(
  parameter int ADDR_W = 12,
  parameter int SETTLE = 8
) (
  input  logic              CLK133,
  input  logic              RST_N,
  input  logic [47:0]       DDS_PINC,
  input  logic              ENABLE,
  input  logic              PHASE_CLR,
  output logic [47:0]       PINC_ACTIVE,
  output logic [47:0]       PHASE,
  output logic [ADDR_W-1:0] WAVE_ADDR,
  output logic              WRAP,
  output logic              PINC_BUSY
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SETTLE = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [47:0] cand_q, cand_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [47:0] pinc_d;
  logic [48:0] sum_p0;

  // Qualifier: state register
  always_ff @(posedge CLK133) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      PINC_ACTIVE <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      PINC_ACTIVE <= pinc_d;
    end
  end

  // Qualifier: next-state logic. A changed value restarts the count.
  // A return to the committed value abandons the candidate.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    pinc_d  = PINC_ACTIVE;
    unique case (state_q)
      S_IDLE: begin
        if (DDS_PINC != PINC_ACTIVE) begin
          cand_d  = DDS_PINC;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (DDS_PINC == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            pinc_d  = cand_q;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (DDS_PINC == PINC_ACTIVE) begin
          state_d = S_IDLE;
        end else begin
          cand_d = DDS_PINC;
          cnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign PINC_BUSY = (state_q == S_SETTLE);

  // Accumulator: 49-bit add, with the carry becoming WRAP. This uses the
  // PINC_ACTIVE value from before the edge, so a commit edge still adds the
  // old increment.
  assign sum_p0 = {1'b0, PHASE} + {1'b0, PINC_ACTIVE};

  always_ff @(posedge CLK133) begin
    if (!RST_N) begin
      PHASE <= '0;
      WRAP  <= 1'b0;
    end else if (PHASE_CLR) begin
      PHASE <= '0;
      WRAP  <= 1'b0;
    end else if (ENABLE) begin
      PHASE <= sum_p0[47:0];
      WRAP  <= sum_p0[48];
    end else begin
      WRAP  <= 1'b0;
    end
  end

  assign WAVE_ADDR = PHASE[47 -: ADDR_W];

endmodule

// File: tb/tb_dds_phase_acc.sv
module tb_dds_phase_acc;

  logic        CLK133 = 1'b0;
  logic        RST_N;
  logic [47:0] DDS_PINC;
  logic        ENABLE;
  logic        PHASE_CLR;
  logic [47:0] PINC_ACTIVE;
  logic [47:0] PHASE;
  logic [11:0] WAVE_ADDR;
  logic        WRAP;
  logic        PINC_BUSY;

  int n_vec = 0;
  int n_err = 0;

  dds_phase_acc #(.ADDR_W(12), .SETTLE(8)) dut (
    .CLK133      (CLK133),
    .RST_N       (RST_N),
    .DDS_PINC    (DDS_PINC),
    .ENABLE      (ENABLE),
    .PHASE_CLR   (PHASE_CLR),
    .PINC_ACTIVE (PINC_ACTIVE),
    .PHASE       (PHASE),
    .WAVE_ADDR   (WAVE_ADDR),
    .WRAP        (WRAP),
    .PINC_BUSY   (PINC_BUSY)
  );

  always #5 CLK133 = ~CLK133;

  typedef struct {
    logic        rst_n;
    logic [47:0] pinc;
    logic        en;
    logic        clr;
    logic [47:0] e_act;
    logic [47:0] e_ph;
    logic        e_wrap;
    logic        e_busy;
    logic [11:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst_n, logic [47:0] pinc, logic en, logic clr,
                              logic [47:0] e_act, logic [47:0] e_ph, logic e_wrap,
                              logic e_busy, logic [11:0] e_addr);
    vec_t v;
    v.rst_n = rst_n; v.pinc = pinc; v.en = en; v.clr = clr;
    v.e_act = e_act; v.e_ph = e_ph; v.e_wrap = e_wrap; v.e_busy = e_busy;
    v.e_addr = e_addr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, settle outputs away from the edge.
  task automatic step(input logic rst_n, input logic [47:0] pinc, input logic en,
                      input logic clr);
    RST_N = rst_n; DDS_PINC = pinc; ENABLE = en; PHASE_CLR = clr;
    @(posedge CLK133);
    #1;
  endtask

  // Commit a new increment with the accumulator idle. The value must differ
  // from the current PINC_ACTIVE. Capture happens on the first edge, and the
  // commit lands 8 edges later.
  task automatic commit(input logic [47:0] val, input logic clr);
    for (int i = 0; i < 9; i++) step(1'b1, val, 1'b0, clr);
    chk($sformatf("commit_%h", val), {16'h0, PINC_ACTIVE}, {16'h0, val});
  endtask

  initial begin
    logic [47:0] old_v, new_v, a_v, b_v, c_v, exp_ph;

    // Reset with a pending nonzero increment, then qualification after release.
    add(1'b0, 48'h1234, 1'b0, 1'b0, 48'h0, 48'h0, 1'b0, 1'b0, 12'h000);
    add(1'b0, 48'h1234, 1'b0, 1'b0, 48'h0, 48'h0, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < 8; i++)
      add(1'b1, 48'h1234, 1'b0, 1'b0, 48'h0, 48'h0, 1'b0, 1'b1, 12'h000);
    add(1'b1, 48'h1234, 1'b0, 1'b0, 48'h1234, 48'h0, 1'b0, 1'b0, 12'h000);
    add(1'b1, 48'h1234, 1'b0, 1'b0, 48'h1234, 48'h0, 1'b0, 1'b0, 12'h000);
    // Commit quarter-turn increment.
    for (int i = 0; i < 8; i++)
      add(1'b1, 48'h4000_0000_0000, 1'b0, 1'b0, 48'h1234, 48'h0, 1'b0, 1'b1, 12'h000);
    add(1'b1, 48'h4000_0000_0000, 1'b0, 1'b0, 48'h4000_0000_0000, 48'h0, 1'b0, 1'b0, 12'h000);
    // Accumulate and wrap every 4 cycles.
    add(1'b1, 48'h4000_0000_0000, 1'b1, 1'b0, 48'h4000_0000_0000, 48'h4000_0000_0000, 1'b0, 1'b0, 12'h400);
    add(1'b1, 48'h4000_0000_0000, 1'b1, 1'b0, 48'h4000_0000_0000, 48'h8000_0000_0000, 1'b0, 1'b0, 12'h800);
    add(1'b1, 48'h4000_0000_0000, 1'b1, 1'b0, 48'h4000_0000_0000, 48'hC000_0000_0000, 1'b0, 1'b0, 12'hC00);
    add(1'b1, 48'h4000_0000_0000, 1'b1, 1'b0, 48'h4000_0000_0000, 48'h0000_0000_0000, 1'b1, 1'b0, 12'h000);
    add(1'b1, 48'h4000_0000_0000, 1'b1, 1'b0, 48'h4000_0000_0000, 48'h4000_0000_0000, 1'b0, 1'b0, 12'h400);
    add(1'b1, 48'h4000_0000_0000, 1'b1, 1'b0, 48'h4000_0000_0000, 48'h8000_0000_0000, 1'b0, 1'b0, 12'h800);
    add(1'b1, 48'h4000_0000_0000, 1'b1, 1'b0, 48'h4000_0000_0000, 48'hC000_0000_0000, 1'b0, 1'b0, 12'hC00);
    // Hold, then clear.
    add(1'b1, 48'h4000_0000_0000, 1'b0, 1'b0, 48'h4000_0000_0000, 48'hC000_0000_0000, 1'b0, 1'b0, 12'hC00);
    add(1'b1, 48'h4000_0000_0000, 1'b0, 1'b0, 48'h4000_0000_0000, 48'hC000_0000_0000, 1'b0, 1'b0, 12'hC00);
    add(1'b1, 48'h4000_0000_0000, 1'b1, 1'b1, 48'h4000_0000_0000, 48'h0, 1'b0, 1'b0, 12'h000);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].pinc, vecs[i].en, vecs[i].clr);
      chk($sformatf("v%0d_active", i), {16'h0, PINC_ACTIVE}, {16'h0, vecs[i].e_act});
      chk($sformatf("v%0d_phase", i),  {16'h0, PHASE},       {16'h0, vecs[i].e_ph});
      chk($sformatf("v%0d_wrap", i),   {63'h0, WRAP},        {63'h0, vecs[i].e_wrap});
      chk($sformatf("v%0d_busy", i),   {63'h0, PINC_BUSY},   {63'h0, vecs[i].e_busy});
      chk($sformatf("v%0d_addr", i),   {52'h0, WAVE_ADDR},   {52'h0, vecs[i].e_addr});
    end

    // Clear against a simultaneous overflow: PHASE=all-ones, PINC=1.
    commit(48'hFFFF_FFFF_FFFF, 1'b0);
    step(1'b1, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0);
    chk("ones_phase", {16'h0, PHASE}, {16'h0, 48'hFFFF_FFFF_FFFF});
    chk("ones_addr", {52'h0, WAVE_ADDR}, {52'h0, 12'hFFF});
    commit(48'h1, 1'b0);
    chk("pre_clr_phase", {16'h0, PHASE}, {16'h0, 48'hFFFF_FFFF_FFFF});
    step(1'b1, 48'h1, 1'b1, 1'b1);
    chk("clr_ovf_phase", {16'h0, PHASE}, 64'h0);
    chk("clr_ovf_wrap", {63'h0, WRAP}, 64'h0);
    step(1'b1, 48'h1, 1'b1, 1'b0);
    chk("after_clr_phase", {16'h0, PHASE}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 48'h1, 1'b0, 1'b0);
      chk($sformatf("frozen%0d_phase", i), {16'h0, PHASE}, 64'h1);
      chk($sformatf("frozen%0d_wrap", i), {63'h0, WRAP}, 64'h0);
    end

    // Word-wise update: L, M, H words written on edges 0, 3, 6.
    old_v = 48'h0005_0006_0007;
    a_v   = 48'h0005_0006_0000;
    b_v   = 48'h0005_0001_0000;
    c_v   = 48'h0000_0001_0000;
    new_v = c_v;
    commit(old_v, 1'b1);
    for (int e = 0; e < 16; e++) begin
      step(1'b1, (e < 3) ? a_v : (e < 6) ? b_v : c_v, 1'b0, 1'b1);
      chk($sformatf("word_e%0d_active", e), {16'h0, PINC_ACTIVE},
          {16'h0, (e >= 14) ? new_v : old_v});
      chk($sformatf("word_e%0d_busy", e), {63'h0, PINC_BUSY}, {63'h0, (e < 14)});
    end

    // Revert: 0x100 -> 0x200 for 3 edges -> back to 0x100.
    commit(48'h100, 1'b1);
    for (int e = 0; e < 14; e++) begin
      step(1'b1, (e < 3) ? 48'h200 : 48'h100, 1'b0, 1'b1);
      chk($sformatf("revert_e%0d_active", e), {16'h0, PINC_ACTIVE}, 64'h100);
      chk($sformatf("revert_e%0d_busy", e), {63'h0, PINC_BUSY}, {63'h0, (e < 3)});
    end

    // Commit boundary: increment 1 -> 2 while accumulating from 0.
    commit(48'h1, 1'b1);
    for (int j = 0; j < 11; j++) begin
      step(1'b1, 48'h2, 1'b1, 1'b0);
      exp_ph = (j <= 8) ? 48'(j + 1) : 48'(9 + 2 * (j - 8));
      chk($sformatf("bound_j%0d_phase", j), {16'h0, PHASE}, {16'h0, exp_ph});
    end
    chk("bound_active", {16'h0, PINC_ACTIVE}, 64'h2);

    // Reset in mid-settle aborts the candidate.
    step(1'b1, 48'h77, 1'b0, 1'b0);
    step(1'b1, 48'h77, 1'b0, 1'b0);
    step(1'b0, 48'h77, 1'b0, 1'b0);
    chk("rst_mid_active", {16'h0, PINC_ACTIVE}, 64'h0);
    chk("rst_mid_busy", {63'h0, PINC_BUSY}, 64'h0);
    chk("rst_mid_phase", {16'h0, PHASE}, 64'h0);
    commit(48'h77, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dds_phase_acc.md
# dds_phase_acc

Phase accumulator stage fed by the bus register decoder's 48-bit DDS phase-increment output. The decoder updates that increment one 16-bit word at a time, so this block qualifies each new value (stable for SETTLE cycles) before committing it. This keeps a half-written increment from ever reaching the accumulator. It then accumulates phase at CLK133 and presents the top bits as the waveform-table read address, with a wrap pulse per output period.

## Interface

Parameters:
- ADDR_W, 12, waveform-table address width; WAVE_ADDR = PHASE[47:48-ADDR_W]; legal range 1..32
- SETTLE, 8, consecutive stable cycles required before a new increment is committed; legal range 1..255

Ports:
- CLK133  in  1  system clock, 133 MHz, all logic on rising edge
- RST_N  in  1  reset; synchronous, active-low
- DDS_PINC  in  48  raw phase increment from bus register decoder (may change word-by-word)
- ENABLE  in  1  1 = accumulate each cycle, 0 = hold phase
- PHASE_CLR  in  1  synchronous phase clear, priority over ENABLE
- PINC_ACTIVE  out  48  committed increment in use by accumulator
- PHASE  out  48  accumulator register
- WAVE_ADDR  out  ADDR_W  PHASE[47:48-ADDR_W], combinational from PHASE
- WRAP  out  1  one-cycle pulse, carry out of the 48-bit add
- PINC_BUSY  out  1  1 while a candidate increment is settling (state == SETTLE)

## Operation

- Internal registers: state (IDLE/SETTLE), CAND[47:0], CNT[7:0].
- Reset (RST_N=0 at an edge): state=IDLE, CAND=0, CNT=0, PINC_ACTIVE=0, PHASE=0, WRAP=0. PINC_BUSY=0 and WAVE_ADDR=0 follow.
- Qualifier FSM:
  - IDLE: if DDS_PINC != PINC_ACTIVE, then CAND<=DDS_PINC, CNT<=0, go to SETTLE. Otherwise stay.
  - SETTLE, DDS_PINC == CAND: if CNT == SETTLE-1, then PINC_ACTIVE<=CAND and go to IDLE. Otherwise CNT<=CNT+1.
  - SETTLE, DDS_PINC != CAND and DDS_PINC == PINC_ACTIVE: the value reverted. Go to IDLE, no commit.
  - SETTLE, DDS_PINC != CAND and != PINC_ACTIVE: CAND<=DDS_PINC, CNT<=0, stay in SETTLE (restart).
- Accumulator, evaluated every edge:
  - PHASE_CLR=1: PHASE<=0, WRAP<=0.
  - else ENABLE=1: {c,sum}=PHASE+PINC_ACTIVE (49-bit); PHASE<=sum[47:0] (modulo 2^48), WRAP<=c.
  - else: PHASE holds, WRAP<=0.
- The accumulator always uses the registered PINC_ACTIVE value present before the edge. A commit edge therefore still adds the old increment.
- PHASE_CLR and ENABLE do not affect the qualifier FSM. The FSM does not affect PHASE except through PINC_ACTIVE.
- PINC=0 with ENABLE=1: PHASE holds, WRAP stays 0.

## Timing

- Commit latency: DDS_PINC first differs at edge k (captured there). If it is stable, PINC_ACTIVE updates at edge k+SETTLE, and PHASE first uses the new increment at edge k+SETTLE+1.
- PINC_BUSY goes 1 after edge k and returns to 0 after the commit, revert or reset edge.
- PHASE/WRAP update latency from ENABLE: 1 cycle. WRAP is high for exactly the cycle after the overflowing add.
- WAVE_ADDR has zero latency relative to PHASE.
- Reset mid-SETTLE aborts the candidate: PINC_ACTIVE=0. If DDS_PINC is nonzero at the first edge after reset release, qualification restarts from that edge.
- Simultaneous PHASE_CLR and overflow: clear wins, WRAP=0.
- Sustained throughput: one accumulate per cycle, no stalls.

## Test plan

- Reset: hold RST_N=0 two edges with DDS_PINC=0x1234 -> all outputs 0. Release -> PINC_BUSY=1 for SETTLE=8 cycles, then PINC_ACTIVE=0x000000001234.
- Word-wise update: write L=0x0000, M=0x0001, H=0x0000 on cycles 0/3/6 (SETTLE=8) -> single commit of 0x000000010000 at edge 6+8=14, no intermediate value on PINC_ACTIVE.
- Revert: change DDS_PINC from 0x100 to 0x200 for 3 cycles, then back to 0x100 -> PINC_BUSY drops, PINC_ACTIVE stays 0x100, no commit.
- Accumulate/wrap: PINC_ACTIVE=0x4000_0000_0000, ENABLE=1 -> PHASE cycles through 4000…, 8000…, C000…, 0. WRAP is 1 exactly on the cycle PHASE=0, every 4 cycles. WAVE_ADDR (ADDR_W=12) = 0x400, 0x800, 0xC00, 0x000.
- PHASE_CLR with ENABLE=1 and PHASE=0xFFFF_FFFF_FFFF, PINC=1 -> PHASE=0, WRAP=0 next cycle. ENABLE=0 -> PHASE frozen, WRAP=0.
- Commit boundary: PINC_ACTIVE 1 -> 2, ENABLE=1 from PHASE=0 -> PHASE increments by 1 through the commit edge, by 2 afterwards.
